// File: rtl/ysyx_24100006_pkg.sv
// Shared definitions for the ysyx_24100006 instruction fetch unit.
package ysyx_24100006_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned RESP_W    = 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // AXI-style read response code for a successful access
    localparam logic [RESP_W-1:0] RESP_OKAY = 2'b00;

    // Fetch FSM: REQ drives arvalid, WAIT/DROP drive rready, HOLD drives out_valid
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ysyx_24100006_ifu.sv
// Instruction fetch unit: issues one instruction-memory read at a time and hands
// the result to IF_ID over a valid/ready link, squashing fetches made stale by a
// redirect. Optional macro IFU_SKID_BUF_EN overlaps the next address request with
// the HOLD cycle in which the current instruction is accepted.
module ysyx_24100006_ifu
    import ysyx_24100006_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        arvalid_o,
    input  logic        arready_i,
    output logic [31:0] araddr_o,
    input  logic        rvalid_i,
    output logic        rready_o,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        fetch_err_o
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] instr_q;
    logic [31:0] pc_out_q;
    logic        err_q;
    logic        load_out;
    logic        ar_hs;

    assign ar_hs = arvalid_o && arready_i;

    // State register with synchronous reset; a reset abandons any read in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // Next-state logic: redirects either retarget pc_q directly or park in pend_pc_q
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        load_out  = 1'b0;
        case (state_q)
            ST_REQ: begin
                // Address must stay put until accepted, so a redirect is deferred
                if (redirect_valid_i) begin
                    pend_d    = 1'b1;
                    pend_pc_d = redirect_pc_i;
                end
                if (ar_hs) begin
                    state_d = (pend_q || redirect_valid_i) ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid_i) begin
                    if (rvalid_i) begin
                        pc_d    = redirect_pc_i;
                        state_d = ST_REQ;
                    end else begin
                        pend_d    = 1'b1;
                        pend_pc_d = redirect_pc_i;
                        state_d   = ST_DROP;
                    end
                end else if (rvalid_i) begin
                    load_out = 1'b1;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect_valid_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = ST_REQ;
                end else if (out_ready) begin
                    pc_d = pc_q + PC_STEP;
`ifdef IFU_SKID_BUF_EN
                    state_d = arready_i ? ST_WAIT : ST_REQ;
`else
                    state_d = ST_REQ;
`endif
                end
            end
            ST_DROP: begin
                // Latest redirect wins; the returning data is discarded either way
                if (redirect_valid_i) begin
                    if (rvalid_i) begin
                        pc_d    = redirect_pc_i;
                        pend_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        pend_pc_d = redirect_pc_i;
                    end
                end else if (rvalid_i) begin
                    pc_d    = pend_pc_q;
                    pend_d  = 1'b0;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // Handshake outputs decoded from the state register, forced idle during reset
    always_comb begin
        arvalid_o = 1'b0;
        rready_o  = 1'b0;
        out_valid = 1'b0;
        araddr_o  = pc_q;
        if (!reset) begin
            case (state_q)
                ST_REQ:  arvalid_o = 1'b1;
                ST_WAIT: rready_o  = 1'b1;
                ST_DROP: rready_o  = 1'b1;
                ST_HOLD: begin
                    out_valid = 1'b1;
`ifdef IFU_SKID_BUF_EN
                    // Issue the sequential fetch while the current one is being taken
                    arvalid_o = out_ready && !redirect_valid_i;
                    araddr_o  = pc_q + PC_STEP;
`endif
                end
                default: begin
                    arvalid_o = 1'b0;
                end
            endcase
        end
    end

    // Output payload registers; not reset because out_valid qualifies them
    always_ff @(posedge clk) begin
        if (load_out) begin
            instr_q  <= rdata_i;
            pc_out_q <= pc_q;
            err_q    <= (rresp_i != RESP_OKAY);
        end
    end

    assign instruction_o = instr_q;
    assign pc_o          = pc_out_q;
    assign fetch_err_o   = err_q;

endmodule
